// File: rtl/frame_scheduler.sv
// Frame sequencer for the counter link: snapshots all channels on a periodic tick or
// on trigger, then sends a 0xFF header and one encoded byte per channel to the UART TX.
module frame_scheduler #(
    parameter int NUM_CH = 4,
    parameter int PERIOD = 1000,
    parameter int THRESH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic [8*NUM_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_sig,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SNAP   = 3'd1;
    localparam logic [2:0] S_HEADER = 3'd2;
    localparam logic [2:0] S_CHAN   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Small counts carry the switch level; 0xFF is reserved for the header byte.
    function automatic logic [7:0] enc(input logic [7:0] d, input logic s);
        if (d < 8'(THRESH))
            return s ? 8'h01 : 8'h02;
        else if (d == 8'hFF)
            return 8'hFE;
        else
            return d;
    endfunction

    logic [CNT_W-1:0]    cnt_reg;
    logic [2:0]          state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [8*NUM_CH-1:0] snap_data_reg;
    logic [NUM_CH-1:0]   snap_sig_reg;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic                tx_valid_reg;
    logic                busy_reg;
    logic                frame_done_reg;
    logic                overrun_reg;
    logic                tc;
    logic                req;
    logic                hs;
    logic [7:0]          enc_byte [NUM_CH];

    assign tc  = enable & (cnt_reg == CNT_LAST);
    assign req = tc | trigger;
    assign hs  = tx_valid_reg & tx_ready;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_reg <= '0;
        else if (!enable || cnt_reg == CNT_LAST)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_data_reg <= '0;
            snap_sig_reg  <= '0;
        end else if (state_reg == S_SNAP) begin
            snap_data_reg <= ch_data;
            snap_sig_reg  <= ch_sig;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_enc
            assign enc_byte[gi] = enc(snap_data_reg[8*gi +: 8], snap_sig_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE:   if (req) state_next = S_SNAP;
            S_SNAP: begin
                idx_next   = '0;
                state_next = S_HEADER;
            end
            S_HEADER: if (hs) state_next = S_CHAN;
            S_CHAN: begin
                if (hs) begin
                    if (idx_reg == IDX_LAST)
                        state_next = S_DONE;
                    else
                        idx_next = idx_reg + IDX_W'(1);
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        tx_data_next = 8'h00;
        case (state_next)
            S_HEADER: tx_data_next = 8'hFF;
            S_CHAN:   tx_data_next = enc_byte[idx_next];
            default:  tx_data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            tx_data_reg    <= 8'h00;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= (state_next == S_HEADER) || (state_next == S_CHAN);
            busy_reg       <= (state_next != S_IDLE);
            frame_done_reg <= (state_next == S_DONE);
            if (req && state_reg != S_IDLE)
                overrun_reg <= 1'b1;
        end
    end

    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule
